// File: rtl/gcn_argmax.sv
`default_nettype none
// ============================================================================
// Module      : gcn_argmax
// Description : Final GCN stage. Scans each row of the ADJ*FM*WM product and
//               holds the column index of the largest entry per node.
// Revision    : 1.0 - initial release
// ============================================================================
module gcn_argmax #(
  parameter int DOT_PROD_ROWS       = 6,
  parameter int DOT_PROD_COLS       = 3,
  parameter int ADJ_DOT_PROD_WIDTH  = 16,
  parameter int DOT_PROD_ROWS_WIDTH = $clog2(DOT_PROD_ROWS),
  parameter int MAX_ADDR_WIDTH      = $clog2(DOT_PROD_COLS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           done_comb,
  input  logic [ADJ_DOT_PROD_WIDTH-1:0]  ADJ_FM_WM_Row [0:DOT_PROD_COLS-1],
  output logic [DOT_PROD_ROWS_WIDTH-1:0] read_row_ADJ_FM_WM,
  output logic [MAX_ADDR_WIDTH-1:0]      max_addi_answer [0:DOT_PROD_ROWS-1],
  output logic                           done
);

  localparam logic [DOT_PROD_ROWS_WIDTH-1:0] c_LAST_ROW =
    DOT_PROD_ROWS_WIDTH'(DOT_PROD_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                           r_state;
  logic [DOT_PROD_ROWS_WIDTH-1:0]   r_row;
  logic                             r_done;
  logic [MAX_ADDR_WIDTH-1:0]        r_answer [0:DOT_PROD_ROWS-1];

  logic [ADJ_DOT_PROD_WIDTH-1:0]    w_max_val;
  logic [MAX_ADDR_WIDTH-1:0]        w_max_idx;

  // Strictly-greater linear scan: ties keep the lowest column index.
  always_comb begin
    w_max_val = ADJ_FM_WM_Row[0];
    w_max_idx = '0;
    for (int i = 1; i < DOT_PROD_COLS; i++) begin
      if (ADJ_FM_WM_Row[i] > w_max_val) begin
        w_max_val = ADJ_FM_WM_Row[i];
        w_max_idx = MAX_ADDR_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < DOT_PROD_ROWS; i++) begin
        r_answer[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_row <= '0;
          if (done_comb) begin
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          r_answer[r_row] <= w_max_idx;
          if (r_row == c_LAST_ROW) begin
            r_state <= S_DONE;
          end else begin
            r_row   <= r_row + 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_DONE: begin
          // Only reset leaves this state; done_comb is ignored here.
          r_done <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Address is presented for both ADDR and EVAL so a registered-read memory
  // has its data ready by EVAL.
  assign read_row_ADJ_FM_WM = ((r_state == S_ADDR) || (r_state == S_EVAL)) ? r_row : '0;
  assign max_addi_answer    = r_answer;
  assign done               = r_done;

endmodule
`default_nettype wire
